// File: rtl/frame_pkg.sv
// Shared definitions for the frame block sequencer.
//   BLK     : block edge length in pixels (blocks are BLK x BLK)
//   state_t : sequencer states (IDLE, RUN, DONE)
package frame_pkg;

    localparam int BLK = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/sw_sync.sv
// Two-flop synchronizer with a registered previous value, giving a
// one-cycle rising-edge indication in the clk_i domain.
// Ports:
//   clk_i   : clock
//   rst_i   : synchronous active-high reset, clears all flops
//   async_i : asynchronous level input
//   rise_o  : 1 for one cycle when the synchronized level goes 0 -> 1
module sw_sync (
    input  logic clk_i,
    input  logic rst_i,
    input  logic async_i,
    output logic rise_o
);

    logic meta_q;
    logic sync_q;
    logic prev_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
            prev_q <= 1'b0;
        end else begin
            meta_q <= async_i;
            sync_q <= meta_q;
            prev_q <= sync_q;
        end
    end

    // Edge flop cleared by reset: a level still high after reset yields a rise.
    assign rise_o = sync_q & ~prev_q;

endmodule

// File: rtl/frame_block_sequencer.sv
// Frame block sequencer: on a start request, emits every pixel address of
// a FRAME_W x FRAME_H frame in 8x8 block order (block rows, block columns,
// pixel rows, pixel columns) over a valid/ready stream, then pulses done
// and counts the frame.
// Ports:
//   csi_clk, rsi_reset      : clock, synchronous active-high reset
//   coe_c0_SW0, coe_c0_SW1  : async start request / mode select
//   aso_out_*               : address stream (valid, ready, data, sob, eof, mode)
//   coe_busy                : frame in progress (RUN or DONE)
//   coe_frame_done          : one-cycle pulse after the final beat
//   coe_frame_count         : completed frame count, wraps at 16 bits
module frame_block_sequencer
    import frame_pkg::*;
#(
    parameter int FRAME_W = 320,
    parameter int FRAME_H = 240,
    parameter int ADDR_W  = 17
) (
    input  logic              csi_clk,
    input  logic              rsi_reset,
    input  logic              coe_c0_SW0,
    input  logic              coe_c0_SW1,
    output logic              aso_out_valid,
    input  logic              aso_out_ready,
    output logic [ADDR_W-1:0] aso_out_data,
    output logic              aso_out_sob,
    output logic              aso_out_eof,
    output logic              aso_out_mode,
    output logic              coe_busy,
    output logic              coe_frame_done,
    output logic [15:0]       coe_frame_count
);

    localparam int BX_N = FRAME_W / BLK;
    localparam int BY_N = FRAME_H / BLK;
    localparam int BXW  = (BX_N > 1) ? $clog2(BX_N) : 1;
    localparam int BYW  = (BY_N > 1) ? $clog2(BY_N) : 1;
    localparam logic [BXW-1:0]    BX_LAST  = BXW'(BX_N - 1);
    localparam logic [BYW-1:0]    BY_LAST  = BYW'(BY_N - 1);
    localparam logic [ADDR_W-1:0] ROW_STEP = ADDR_W'(FRAME_W);
    localparam logic [ADDR_W-1:0] BLK_STEP = ADDR_W'(BLK);

    logic sw0_rise;
    logic sw1_meta_q, sw1_sync_q;

    state_t            state_q, state_d;
    logic [2:0]        c_q, c_d, r_q, r_d;
    logic [BXW-1:0]    bx_q, bx_d;
    logic [BYW-1:0]    by_q, by_d;
    logic [ADDR_W-1:0] blk_base_q, blk_base_d;
    logic [ADDR_W-1:0] row_base_q, row_base_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              mode_q, mode_d;
    logic [15:0]       frame_count_q;

    logic last_c, last_r, last_bx, last_by, eof_beat;

    sw_sync u_sw0_sync (
        .clk_i  (csi_clk),
        .rst_i  (rsi_reset),
        .async_i(coe_c0_SW0),
        .rise_o (sw0_rise)
    );

    // Mode select only needs a level, so no edge flop.
    always_ff @(posedge csi_clk) begin
        if (rsi_reset) begin
            sw1_meta_q <= 1'b0;
            sw1_sync_q <= 1'b0;
        end else begin
            sw1_meta_q <= coe_c0_SW1;
            sw1_sync_q <= sw1_meta_q;
        end
    end

    assign last_c   = (c_q == 3'd7);
    assign last_r   = (r_q == 3'd7);
    assign last_bx  = (bx_q == BX_LAST);
    assign last_by  = (by_q == BY_LAST);
    assign eof_beat = last_c & last_r & last_bx & last_by;

    always_ff @(posedge csi_clk) begin
        if (rsi_reset) state_q <= IDLE;
        else           state_q <= state_d;
    end

    // Address is advanced incrementally: blk_base tracks the block origin,
    // row_base the start of the current pixel row within the block.
    always_comb begin
        state_d    = state_q;
        mode_d     = mode_q;
        c_d        = c_q;
        r_d        = r_q;
        bx_d       = bx_q;
        by_d       = by_q;
        blk_base_d = blk_base_q;
        row_base_d = row_base_q;
        addr_d     = addr_q;
        case (state_q)
            IDLE: begin
                if (sw0_rise) begin
                    state_d = RUN;
                    mode_d  = sw1_sync_q;
                end
            end
            RUN: begin
                if (aso_out_ready) begin
                    if (eof_beat) begin
                        state_d    = DONE;
                        c_d        = 3'd0;
                        r_d        = 3'd0;
                        bx_d       = '0;
                        by_d       = '0;
                        blk_base_d = '0;
                        row_base_d = '0;
                        addr_d     = '0;
                    end else if (!last_c) begin
                        c_d    = c_q + 3'd1;
                        addr_d = addr_q + ADDR_W'(1);
                    end else begin
                        c_d = 3'd0;
                        if (!last_r) begin
                            r_d        = r_q + 3'd1;
                            row_base_d = row_base_q + ROW_STEP;
                            addr_d     = row_base_q + ROW_STEP;
                        end else begin
                            r_d = 3'd0;
                            if (!last_bx) begin
                                bx_d       = bx_q + BXW'(1);
                                blk_base_d = blk_base_q + BLK_STEP;
                                row_base_d = blk_base_q + BLK_STEP;
                                addr_d     = blk_base_q + BLK_STEP;
                            end else begin
                                // Last pixel of a block row is the frame pixel
                                // just before the next block row's origin.
                                bx_d       = '0;
                                by_d       = by_q + BYW'(1);
                                blk_base_d = addr_q + ADDR_W'(1);
                                row_base_d = addr_q + ADDR_W'(1);
                                addr_d     = addr_q + ADDR_W'(1);
                            end
                        end
                    end
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge csi_clk) begin
        if (rsi_reset) begin
            mode_q     <= 1'b0;
            c_q        <= 3'd0;
            r_q        <= 3'd0;
            bx_q       <= '0;
            by_q       <= '0;
            blk_base_q <= '0;
            row_base_q <= '0;
            addr_q     <= '0;
        end else begin
            mode_q     <= mode_d;
            c_q        <= c_d;
            r_q        <= r_d;
            bx_q       <= bx_d;
            by_q       <= by_d;
            blk_base_q <= blk_base_d;
            row_base_q <= row_base_d;
            addr_q     <= addr_d;
        end
    end

    always_ff @(posedge csi_clk) begin
        if (rsi_reset)             frame_count_q <= 16'd0;
        else if (state_q == DONE)  frame_count_q <= frame_count_q + 16'd1;
    end

    assign aso_out_valid   = (state_q == RUN);
    assign aso_out_data    = addr_q;
    assign aso_out_sob     = (state_q == RUN) && (c_q == 3'd0) && (r_q == 3'd0);
    assign aso_out_eof     = (state_q == RUN) && eof_beat;
    assign aso_out_mode    = mode_q;
    assign coe_busy        = (state_q != IDLE);
    assign coe_frame_done  = (state_q == DONE);
    assign coe_frame_count = frame_count_q;

endmodule

// File: tb/tb_frame_block_sequencer.sv
module tb_frame_block_sequencer;

    localparam int W  = 16;
    localparam int H  = 16;
    localparam int AW = 8;
    localparam int NB = W * H;

    logic          clk = 1'b0;
    logic          rst, sw0, sw1, ready;
    logic          valid, sob, eof, mode, busy, done;
    logic [AW-1:0] data;
    logic [15:0]   count;

    always #5 clk = ~clk;

    frame_block_sequencer #(.FRAME_W(W), .FRAME_H(H), .ADDR_W(AW)) dut (
        .csi_clk        (clk),
        .rsi_reset      (rst),
        .coe_c0_SW0     (sw0),
        .coe_c0_SW1     (sw1),
        .aso_out_valid  (valid),
        .aso_out_ready  (ready),
        .aso_out_data   (data),
        .aso_out_sob    (sob),
        .aso_out_eof    (eof),
        .aso_out_mode   (mode),
        .coe_busy       (busy),
        .coe_frame_done (done),
        .coe_frame_count(count)
    );

    typedef struct {
        int            beat;
        logic [AW-1:0] addr;
        logic          sob;
        logic          eof;
    } vec_t;

    vec_t          tbl[13];
    logic [AW-1:0] cap_addr[NB];
    logic          cap_sob[NB];
    logic          cap_eof[NB];

    int nvec = 0;
    int nmis = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nmis++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [AW-1:0] model_addr(input int k);
        int c, r, blk, bx, by;
        c   = k % 8;
        r   = (k / 8) % 8;
        blk = k / 64;
        bx  = blk % (W / 8);
        by  = blk / (W / 8);
        return AW'((by * 8 + r) * W + bx * 8 + c);
    endfunction

    // Raises SW0 (no-op if already high) and follows one frame to completion.
    task automatic run_frame(input bit rnd_ready, input bit exp_mode, input bit flip_sw1,
                             input bit wiggle_sw0, input logic [15:0] exp_count);
        int          k = 0;
        int          ndone = 0;
        int          cyc = 0;
        bit          stalled = 0;
        bit          finished = 0;
        logic [10:0] held = '0;
        sw0 = 1'b1;
        while (!finished && cyc < 3000) begin
            @(negedge clk);
            cyc++;
            ready = rnd_ready ? ($urandom_range(0, 3) != 0) : 1'b1;
            if (stalled)
                check("stall_hold", {21'd0, data, sob, eof, mode}, {21'd0, held});
            stalled = 0;
            if (valid) begin
                if (ready) begin
                    if (k < NB) begin
                        cap_addr[k] = data;
                        cap_sob[k]  = sob;
                        cap_eof[k]  = eof;
                        check($sformatf("beat%0d", k), {21'd0, data, sob, eof, mode},
                              {21'd0, model_addr(k), (k % 64) == 0, k == NB - 1, exp_mode});
                    end
                    k++;
                    if (flip_sw1 && k == 100) sw1 = 1'b0;
                    if (wiggle_sw0 && (k == 40 || k == 120)) sw0 = 1'b0;
                    if (wiggle_sw0 && (k == 50 || k == 130)) sw0 = 1'b1;
                end else begin
                    stalled = 1;
                    held    = {data, sob, eof, mode};
                end
            end
            if (done) ndone++;
            if (ndone > 0 && !busy) finished = 1;
        end
        check("frame_finished", {31'd0, finished}, 32'd1);
        check("beat_count", k, NB);
        check("done_pulses", ndone, 1);
        check("frame_count", {16'd0, count}, {16'd0, exp_count});
    endtask

    task automatic idle_hold(input int n);
        bit seen = 0;
        repeat (n) begin
            @(negedge clk);
            if (valid || busy) seen = 1;
        end
        check("no_restart", {31'd0, seen}, 32'd0);
    endtask

    initial begin
        tbl[0]  = '{beat: 0,   addr: 8'd0,   sob: 1'b1, eof: 1'b0};
        tbl[1]  = '{beat: 1,   addr: 8'd1,   sob: 1'b0, eof: 1'b0};
        tbl[2]  = '{beat: 2,   addr: 8'd2,   sob: 1'b0, eof: 1'b0};
        tbl[3]  = '{beat: 3,   addr: 8'd3,   sob: 1'b0, eof: 1'b0};
        tbl[4]  = '{beat: 4,   addr: 8'd4,   sob: 1'b0, eof: 1'b0};
        tbl[5]  = '{beat: 5,   addr: 8'd5,   sob: 1'b0, eof: 1'b0};
        tbl[6]  = '{beat: 6,   addr: 8'd6,   sob: 1'b0, eof: 1'b0};
        tbl[7]  = '{beat: 7,   addr: 8'd7,   sob: 1'b0, eof: 1'b0};
        tbl[8]  = '{beat: 8,   addr: 8'd16,  sob: 1'b0, eof: 1'b0};
        tbl[9]  = '{beat: 64,  addr: 8'd8,   sob: 1'b1, eof: 1'b0};
        tbl[10] = '{beat: 128, addr: 8'd128, sob: 1'b1, eof: 1'b0};
        tbl[11] = '{beat: 192, addr: 8'd136, sob: 1'b1, eof: 1'b0};
        tbl[12] = '{beat: 255, addr: 8'd255, sob: 1'b0, eof: 1'b1};

        rst = 1'b1; sw0 = 1'b0; sw1 = 1'b0; ready = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_valid", {31'd0, valid}, 32'd0);
        check("rst_data",  {24'd0, data},  32'd0);
        check("rst_flags", {28'd0, sob, eof, mode, busy}, 32'd0);
        check("rst_done",  {31'd0, done},  32'd0);
        check("rst_count", {16'd0, count}, 32'd0);
        rst = 1'b0;
        repeat (3) @(negedge clk);

        // Frame A: ready always high, intra mode
        run_frame(1'b0, 1'b0, 1'b0, 1'b0, 16'd1);
        for (int i = 0; i < 13; i++)
            check($sformatf("tbl_beat%0d", tbl[i].beat),
                  {22'd0, cap_addr[tbl[i].beat], cap_sob[tbl[i].beat], cap_eof[tbl[i].beat]},
                  {22'd0, tbl[i].addr, tbl[i].sob, tbl[i].eof});
        idle_hold(20);
        sw0 = 1'b0;
        repeat (4) @(negedge clk);

        // Frame B: random stalls, mode 1 with SW1 dropped mid-frame, SW0 re-pulsed in RUN
        sw1 = 1'b1;
        repeat (4) @(negedge clk);
        run_frame(1'b1, 1'b1, 1'b1, 1'b1, 16'd2);
        idle_hold(20);
        sw0 = 1'b0;
        repeat (4) @(negedge clk);

        // Reset in the middle of a frame, SW0 kept high across it
        begin
            int  k = 0;
            int  cyc = 0;
            bit  hit = 0;
            sw0 = 1'b1;
            ready = 1'b1;
            while (!hit && cyc < 600) begin
                @(negedge clk);
                cyc++;
                if (valid) begin
                    if (k == 100) begin
                        rst = 1'b1;
                        hit = 1;
                    end else begin
                        k++;
                    end
                end
            end
            check("reached_beat100", {31'd0, hit}, 32'd1);
            @(negedge clk);
            check("midrst_valid", {31'd0, valid}, 32'd0);
            check("midrst_data",  {24'd0, data},  32'd0);
            check("midrst_flags", {28'd0, sob, eof, mode, busy}, 32'd0);
            check("midrst_done",  {31'd0, done},  32'd0);
            check("midrst_count", {16'd0, count}, 32'd0);
            rst = 1'b0;
        end
        run_frame(1'b0, 1'b0, 1'b0, 1'b0, 16'd1);
        sw0 = 1'b0;
        repeat (4) @(negedge clk);

        // Counter wrap
        force dut.frame_count_q = 16'hFFFF;
        @(negedge clk);
        release dut.frame_count_q;
        @(negedge clk);
        check("count_preset", {16'd0, count}, 32'h0000FFFF);
        run_frame(1'b0, 1'b0, 1'b0, 1'b0, 16'h0000);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end

endmodule

// File: doc/frame_block_sequencer.md
FRAME_BLOCK_SEQUENCER -- requirements
Module: frame_block_sequencer

Interface
REQ-001 SHALL have parameter FRAME_W, default 320, frame width in pixels (multiple of 8).
REQ-002 SHALL have parameter FRAME_H, default 240, frame height in pixels (multiple of 8).
REQ-003 SHALL have parameter ADDR_W, default 17, pixel address width (>= clog2(FRAME_W*FRAME_H)).
REQ-004 SHALL have port csi_clk  input  1  sole clock; all logic on its rising edge.
REQ-005 SHALL have port rsi_reset  input  1  reset, synchronous, active-high.
REQ-006 SHALL have port coe_c0_SW0  input  1  frame start request from the frame-control slave; asynchronous to csi_clk.
REQ-007 SHALL have port coe_c0_SW1  input  1  mode select from the frame-control slave (0 intra, 1 difference); asynchronous.
REQ-008 SHALL have port aso_out_valid  output  1  address beat valid.
REQ-009 SHALL have port aso_out_ready  input  1  downstream accepts the beat.
REQ-010 SHALL have port aso_out_data  output  ADDR_W  linear pixel address, row-major in frame.
REQ-011 SHALL have port aso_out_sob  output  1  beat is first pixel of an 8x8 block.
REQ-012 SHALL have port aso_out_eof  output  1  beat is last pixel of the frame.
REQ-013 SHALL have port aso_out_mode  output  1  mode latched at frame start.
REQ-014 SHALL have port coe_busy  output  1  frame in progress.
REQ-015 SHALL have port coe_frame_done  output  1  one-cycle pulse after final beat accepted.
REQ-016 SHALL have port coe_frame_count  output  16  completed frames, wraps 0xFFFF->0.

Function
REQ-017 SHALL pass coe_c0_SW0 and coe_c0_SW1 through two-flop synchronizers before any use.
REQ-018 SHALL detect a start event when synchronized SW0 is 1 and its previous registered value is 0.
REQ-019 SHALL implement states IDLE, RUN, DONE.
REQ-020 IDLE->RUN on the cycle after a start event; synchronized SW1 is latched into aso_out_mode in that same transition.
REQ-021 Start events during RUN or DONE SHALL be ignored and not queued; SW0 falling mid-frame SHALL NOT abort the frame.
REQ-022 In RUN, aso_out_valid SHALL be 1 continuously; a beat transfers when valid and ready are both 1.
REQ-023 While valid=1 and ready=0, aso_out_data, aso_out_sob, aso_out_eof and aso_out_mode SHALL hold stable.
REQ-024 Beat order: block row by (0..FRAME_H/8-1) outermost, block column bx, pixel row r (0..7), pixel column c (0..7) innermost.
REQ-025 aso_out_data SHALL equal (by*8+r)*FRAME_W + bx*8 + c, computed with incremental counters (no multipliers), zero-extended to ADDR_W.
REQ-026 aso_out_sob SHALL be 1 exactly when r=0 and c=0; aso_out_eof SHALL be 1 exactly on the final beat (address FRAME_W*FRAME_H-1).
REQ-027 On transfer of the eof beat: RUN->DONE, valid deasserts the next cycle.
REQ-028 DONE SHALL last one cycle, assert coe_frame_done, increment coe_frame_count, then return to IDLE.
REQ-029 coe_busy SHALL be 1 in RUN and DONE, 0 in IDLE.
REQ-030 A start event detectable in the DONE cycle SHALL be dropped; SW0 must return low and rise again.

Reset
REQ-031 While rsi_reset=1 at a clock edge: state IDLE, aso_out_valid 0, aso_out_data 0, aso_out_sob 0, aso_out_eof 0, aso_out_mode 0, coe_busy 0, coe_frame_done 0, coe_frame_count 0, synchronizer and edge flops 0.
REQ-032 Reset during RUN SHALL abandon the frame with no done pulse; a synchronized SW0 still high after reset SHALL produce a start event (edge flop cleared to 0).

Structure
REQ-033 Package frame_pkg SHALL hold the state enum (IDLE, RUN, DONE) and constant BLK=8.
REQ-034 One sub-module sw_sync SHALL implement the two-flop synchronizer with rising-edge output, instantiated for SW0 (SW1 uses synchronizer output only).

Verification (FRAME_W=16, FRAME_H=16, ADDR_W=8)
REQ-035 Ready held 1, SW0 0->1 -> 256 beats; beats 0..8 addresses 0,1..7,16; sob at beats 0,64,128,192 with addresses 0,8,128,136; eof only at address 255; one done pulse; count=1.
REQ-036 Ready toggled pseudo-randomly -> same 256-address sequence, outputs stable during every stall, no beat lost or duplicated.
REQ-037 SW1=1 at start, SW1 changed to 0 mid-frame -> aso_out_mode 1 for all 256 beats.
REQ-038 SW0 pulsed low/high twice during RUN -> exactly one frame; SW0 left high after DONE -> no second frame until SW0 low then high.
REQ-039 rsi_reset asserted at beat 100 -> all outputs at reset values next cycle, no done pulse, count unchanged at 0.
REQ-040 65536 frames (or count forced to 0xFFFF) -> coe_frame_count wraps to 0 after next frame.
